// File: rtl/sal_axi_pkg.sv
// Purpose: shared AR/R request, tag and response definitions for the read responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sal_axi_pkg;

  localparam int SAL_ID_W   = 4;
  localparam int SAL_ADDR_W = 32;
  localparam int SAL_LEN_W  = 4;

  localparam logic [1:0] RRESP_OKAY   = 2'b00;
  localparam logic [1:0] RRESP_SLVERR = 2'b10;

  // One queued AR request.
  typedef struct packed {
    logic [SAL_ID_W-1:0]   id;
    logic [SAL_ADDR_W-1:0] addr;
    logic [SAL_LEN_W-1:0]  len;
  } ar_req_t;

  // One issued burst awaiting its data beats.
  typedef struct packed {
    logic [SAL_ID_W-1:0]  id;
    logic [SAL_LEN_W-1:0] len;
  } rd_tag_t;

endpackage

// File: rtl/sal_sync_fifo.sv
// Purpose: single-clock first-word-fall-through FIFO with full/empty flags.
// Latency: a push is visible at pop_dat one cycle later.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
module sal_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign pop_dat = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; DEPTH is a power of 2 so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage write; contents need no reset because empty gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/sal_axi_rd_responder.sv
// Purpose: AXI AR/R slave; queues ARs, issues credit-gated bursts, returns R beats in issue order.
// Latency: req_valid one cycle after AR accept; rvalid one cycle after rd_valid.
// Backpressure: arready = AR queue not full; req_* held until req_ready; R held while !rready;
//               the DFI return path never stalls because bursts issue only against free buffer
//               credits. Define SAL_RD_PARITY_EN to check rd_par per beat and answer SLVERR.
module sal_axi_rd_responder
  import sal_axi_pkg::*;
#(
  parameter int ID_W      = SAL_ID_W,
  parameter int ADDR_W    = SAL_ADDR_W,
  parameter int DATA_W    = 128,
  parameter int REQ_DEPTH = 4,
  parameter int BUF_DEPTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arvalid,
  output logic                arready,
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [3:0]          arlen,
  output logic                req_valid,
  input  logic                req_ready,
  output logic [ADDR_W-1:0]   req_addr,
  output logic [3:0]          req_len,
  input  logic                rd_valid,
  input  logic [DATA_W-1:0]   rd_data,
  input  logic [DATA_W/8-1:0] rd_par,
  output logic                rvalid,
  input  logic                rready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast
);

  localparam int CRED_W = $clog2(BUF_DEPTH) + 1;
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(BUF_DEPTH);

`ifdef SAL_RD_PARITY_EN
  localparam int BUF_W = DATA_W + 1;
`else
  localparam int BUF_W = DATA_W;
`endif

  // ---------------- AR queue ----------------
  ar_req_t ar_in;
  ar_req_t ar_head;
  logic    ar_push;
  logic    ar_pop;
  logic    ar_full;
  logic    ar_empty;

  assign arready = !rst && !ar_full;
  assign ar_push = arvalid && arready;
  assign ar_in   = '{id: SAL_ID_W'(arid), addr: SAL_ADDR_W'(araddr), len: arlen};

  sal_sync_fifo #(.WIDTH($bits(ar_req_t)), .DEPTH(REQ_DEPTH)) u_ar_q (
    .clk      (clk),
    .rst      (rst),
    .push     (ar_push),
    .push_dat (ar_in),
    .full     (ar_full),
    .pop      (ar_pop),
    .pop_dat  (ar_head),
    .empty    (ar_empty)
  );

  // ---------------- burst issue ----------------
  rd_tag_t           tag_in;
  rd_tag_t           tag_head;
  logic              tag_full;
  logic              tag_empty;
  logic              tag_pop;
  ar_req_t           req_q;
  logic [CRED_W-1:0] credits;
  logic [CRED_W-1:0] head_beats;
  logic [CRED_W-1:0] issue_beats;
  logic              issue;
  logic              load;
  logic              r_hs;

  // The head stays in the AR queue until the scheduler takes it, so the queue
  // depth alone bounds outstanding-but-unissued requests.
  assign head_beats  = CRED_W'(ar_head.len) + CRED_W'(1);
  assign issue       = req_valid && req_ready;
  assign load        = !req_valid && !ar_empty && !tag_full && (credits >= head_beats);
  assign ar_pop      = issue;
  assign issue_beats = issue ? (CRED_W'(req_q.len) + CRED_W'(1)) : '0;

  // Registered request: latch the head once space is reserved, hold until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_valid <= 1'b0;
      req_q     <= '0;
    end else if (issue) begin
      req_valid <= 1'b0;
    end else if (load) begin
      req_valid <= 1'b1;
      req_q     <= ar_head;
    end
  end

  assign req_addr = ADDR_W'(req_q.addr);
  assign req_len  = req_q.len;

  // Credits are spent when a burst is handed over and returned per R beat sent.
  always_ff @(posedge clk) begin
    if (rst) credits <= CRED_MAX;
    else     credits <= credits - issue_beats + CRED_W'(r_hs);
  end

  assign tag_in = '{id: req_q.id, len: req_q.len};

  sal_sync_fifo #(.WIDTH($bits(rd_tag_t)), .DEPTH(REQ_DEPTH)) u_tag_q (
    .clk      (clk),
    .rst      (rst),
    .push     (issue),
    .push_dat (tag_in),
    .full     (tag_full),
    .pop      (tag_pop),
    .pop_dat  (tag_head),
    .empty    (tag_empty)
  );

  // ---------------- read data buffer ----------------
  logic [BUF_W-1:0] buf_in;
  logic [BUF_W-1:0] buf_head;
  logic             buf_empty;
  logic             buf_full_unused;
  logic             beat_err;

`ifdef SAL_RD_PARITY_EN
  logic [DATA_W/8-1:0] byte_err;

  // Even parity per byte: data byte plus its parity bit must hold an even number of ones.
  always_comb begin
    byte_err = '0;
    for (int b = 0; b < DATA_W/8; b++) begin
      byte_err[b] = ^{rd_data[b*8 +: 8], rd_par[b]};
    end
  end

  assign buf_in   = {|byte_err, rd_data};
  assign beat_err = buf_head[DATA_W];
`else
  logic unused_rd_par;

  assign unused_rd_par = ^rd_par;
  assign buf_in        = rd_data;
  assign beat_err      = 1'b0;
`endif

  sal_sync_fifo #(.WIDTH(BUF_W), .DEPTH(BUF_DEPTH)) u_data_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (rd_valid),
    .push_dat (buf_in),
    .full     (buf_full_unused),
    .pop      (r_hs),
    .pop_dat  (buf_head),
    .empty    (buf_empty)
  );

  // ---------------- R channel ----------------
  logic [SAL_LEN_W-1:0] beat_cnt;
  logic                 beat_last;

  assign rvalid    = !buf_empty;
  assign r_hs      = rvalid && rready;
  assign beat_last = (beat_cnt == tag_head.len);
  assign tag_pop   = r_hs && beat_last;

  assign rid   = rvalid ? ID_W'(tag_head.id) : '0;
  assign rdata = rvalid ? buf_head[DATA_W-1:0] : '0;
  assign rlast = rvalid && beat_last;
  assign rresp = (rvalid && beat_err) ? RRESP_SLVERR : RRESP_OKAY;

  // Beat position within the current burst; wraps to 0 after the last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (r_hs) begin
      beat_cnt <= beat_last ? '0 : beat_cnt + SAL_LEN_W'(1);
    end
  end

  // Returned data must always belong to an issued burst.
  a_rd_has_tag: assert property (@(posedge clk) disable iff (rst) rd_valid |-> !tag_empty);

endmodule

// File: tb/tb_sal_axi_rd_responder.sv
// Purpose: scoreboard bench for sal_axi_rd_responder (AR accept, credit-gated issue, in-order R).
// Latency: expects rvalid one cycle after rd_valid and req_valid after AR acceptance.
// Backpressure: exercises full AR queue, exhausted credits, rready toggling and reset mid-burst.
module tb_sal_axi_rd_responder;

  typedef struct {
    logic [3:0]   id;
    logic [127:0] data;
    logic         last;
    logic [1:0]   resp;
  } exp_r_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  len;
  } exp_q_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         arvalid = 1'b0;
  logic         arready;
  logic [3:0]   arid = '0;
  logic [31:0]  araddr = '0;
  logic [3:0]   arlen = '0;
  logic         req_valid;
  logic         req_ready = 1'b1;
  logic [31:0]  req_addr;
  logic [3:0]   req_len;
  logic         rd_valid = 1'b0;
  logic [127:0] rd_data = '0;
  logic [15:0]  rd_par = '0;
  logic         rvalid;
  logic         rready = 1'b1;
  logic [3:0]   rid;
  logic [127:0] rdata;
  logic [1:0]   rresp;
  logic         rlast;

  int tests = 0;
  int fails = 0;
  int issued_cnt = 0;
  int r_hs_cnt = 0;
  int stall_chk = 0;

  exp_r_t exp_r[$];
  exp_q_t exp_req[$];

  logic         prev_stall = 1'b0;
  logic [3:0]   p_id;
  logic [127:0] p_data;
  logic         p_last;
  logic [1:0]   p_resp;

  sal_axi_rd_responder dut (
    .clk       (clk),
    .rst       (rst),
    .arvalid   (arvalid),
    .arready   (arready),
    .arid      (arid),
    .araddr    (araddr),
    .arlen     (arlen),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_par    (rd_par),
    .rvalid    (rvalid),
    .rready    (rready),
    .rid       (rid),
    .rdata     (rdata),
    .rresp     (rresp),
    .rlast     (rlast)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] good_par(input logic [127:0] d);
    logic [15:0] p;
    for (int i = 0; i < 16; i++) p[i] = ^d[i*8 +: 8];
    return p;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Scoreboard: R beats and scheduler requests compared as they appear; held payload checked on stalls.
  always @(negedge clk) begin
    exp_r_t e;
    exp_q_t q;
    if (!rst) begin
      if (prev_stall) begin
        stall_chk++;
        tests++;
        if (rvalid !== 1'b1 || rid !== p_id || rdata !== p_data || rlast !== p_last || rresp !== p_resp) begin
          fails++;
          $display("FAIL r_stall_stable got rvalid=%0b rid=%0h rlast=%0b rresp=%0d rdata=%0h want rid=%0h rlast=%0b rresp=%0d rdata=%0h",
                   rvalid, rid, rlast, rresp, rdata, p_id, p_last, p_resp, p_data);
        end
      end
      if (rvalid && rready) begin
        r_hs_cnt++;
        tests++;
        if (exp_r.size() == 0) begin
          fails++;
          $display("FAIL r_unexpected got rid=%0h rdata=%0h rlast=%0b want no beat", rid, rdata, rlast);
        end else begin
          e = exp_r.pop_front();
          if (rid !== e.id || rdata !== e.data || rlast !== e.last || rresp !== e.resp) begin
            fails++;
            $display("FAIL r_beat got rid=%0h rlast=%0b rresp=%0d rdata=%0h want rid=%0h rlast=%0b rresp=%0d rdata=%0h",
                     rid, rlast, rresp, rdata, e.id, e.last, e.resp, e.data);
          end
        end
      end
      if (req_valid && req_ready) begin
        issued_cnt++;
        tests++;
        if (exp_req.size() == 0) begin
          fails++;
          $display("FAIL req_unexpected got addr=%0h len=%0d want none", req_addr, req_len);
        end else begin
          q = exp_req.pop_front();
          if (req_addr !== q.addr || req_len !== q.len) begin
            fails++;
            $display("FAIL req_issue got addr=%0h len=%0d want addr=%0h len=%0d", req_addr, req_len, q.addr, q.len);
          end
        end
      end
    end
    prev_stall = !rst && rvalid && !rready;
    p_id   = rid;
    p_data = rdata;
    p_last = rlast;
    p_resp = rresp;
  end

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len, output bit ok);
    exp_q_t q;
    int n = 0;
    arvalid = 1'b1; arid = id; araddr = addr; arlen = len;
    @(negedge clk);
    while (!arready && n < 300) begin @(negedge clk); n++; end
    ok = arready;
    if (ok) begin q.addr = addr; q.len = len; exp_req.push_back(q); end
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic wait_issues(input int target, output bit ok);
    int n = 0;
    while (issued_cnt < target && n < 300) begin @(negedge clk); n++; end
    ok = (issued_cnt >= target);
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(output bit ok);
    int n = 0;
    while (exp_r.size() != 0 && n < 500) begin @(negedge clk); n++; end
    ok = (exp_r.size() == 0);
    @(posedge clk); #1;
  endtask

  task automatic drive_beat(input logic [3:0] id, input logic [127:0] d, input logic last,
                            input bit bad, input bit exp_en);
    exp_r_t e;
    logic [15:0] p;
    p = good_par(d);
    if (bad) p[3] = ~p[3];
    rd_valid = 1'b1; rd_data = d; rd_par = p;
    if (exp_en) begin
      e.id = id; e.data = d; e.last = last;
`ifdef SAL_RD_PARITY_EN
      e.resp = bad ? 2'b10 : 2'b00;
`else
      e.resp = 2'b00;
`endif
      exp_r.push_back(e);
    end
    @(posedge clk); #1;
    rd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (arready !== 1'b0 || req_valid !== 1'b0 || rvalid !== 1'b0 || rlast !== 1'b0 ||
        rresp !== 2'b00 || rid !== 4'h0 || rdata !== 128'h0) begin
      fails++;
      $display("FAIL reset_outputs got arready=%0b req_valid=%0b rvalid=%0b rlast=%0b rresp=%0d rid=%0h rdata=%0h want all zero",
               arready, req_valid, rvalid, rlast, rresp, rid, rdata);
    end
    tests++;
    if (dut.credits !== 5'd16) begin
      fails++; $display("FAIL reset_credits got %0d want 16", dut.credits);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    tests++;
    if (arready !== 1'b1) begin fails++; $display("FAIL reset_arready_release got %0b want 1", arready); end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    bit ok;
    int base = issued_cnt;
    send_ar(4'h0, 32'h0, 4'd0, ok);
    tests++; if (!ok) begin fails++; $display("FAIL single_ar_accept got timeout want accept"); end
    wait_issues(base + 1, ok);
    tests++; if (!ok) begin fails++; $display("FAIL single_issue got %0d issues want %0d", issued_cnt, base + 1); end
    tests++; if (rvalid !== 1'b0) begin fails++; $display("FAIL single_rvalid_early got %0b want 0", rvalid); end
    drive_beat(4'h0, {16{8'hA5}}, 1'b1, 1'b0, 1'b1);
    tests++; if (rvalid !== 1'b1) begin fails++; $display("FAIL single_latency got rvalid=%0b want 1", rvalid); end
    wait_drain(ok);
    tests++; if (!ok) begin fails++; $display("FAIL single_drain got %0d pending want 0", exp_r.size()); end
  endtask

  task automatic test_two_bursts();
    bit ok, ok2;
    int base = issued_cnt;
    send_ar(4'h1, 32'h100, 4'd3, ok);
    send_ar(4'h2, 32'h200, 4'd3, ok2);
    tests++; if (!(ok && ok2)) begin fails++; $display("FAIL two_ar_accept got %0b%0b want 11", ok, ok2); end
    wait_issues(base + 2, ok);
    tests++; if (!ok) begin fails++; $display("FAIL two_issue got %0d want %0d", issued_cnt, base + 2); end
    for (int k = 0; k < 8; k++) drive_beat((k < 4) ? 4'h1 : 4'h2, rnd128(), (k % 4) == 3, 1'b0, 1'b1);
    wait_drain(ok);
    tests++; if (!ok) begin fails++; $display("FAIL two_drain got %0d pending want 0", exp_r.size()); end
  endtask

  task automatic test_ar_full();
    bit ok, all_ok, blocked, seen_ok;
    exp_q_t q;
    int n;
    int base = issued_cnt;
    req_ready = 1'b0;
    all_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send_ar(4'(8 + k), 32'h1000 + 32'(k * 64), 4'd0, ok);
      all_ok = all_ok && ok;
    end
    tests++; if (!all_ok) begin fails++; $display("FAIL full_first4 got timeout want 4 accepts"); end
    arvalid = 1'b1; arid = 4'hC; araddr = 32'h1100; arlen = 4'd0;
    blocked = 1'b1;
    repeat (3) begin @(negedge clk); if (arready) blocked = 1'b0; end
    tests++; if (!blocked) begin fails++; $display("FAIL full_block got arready=1 want 0 with 4 queued"); end
    @(posedge clk); #1 req_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!arready && n < 100) begin @(negedge clk); n++; end
    seen_ok = arready && (issued_cnt >= base + 1);
    tests++;
    if (!seen_ok) begin
      fails++; $display("FAIL full_fifth_accept got arready=%0b issues=%0d want 1 after >=%0d", arready, issued_cnt, base + 1);
    end
    q.addr = 32'h1100; q.len = 4'd0; exp_req.push_back(q);
    @(posedge clk); #1 arvalid = 1'b0;
    all_ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_issues(base + k + 1, ok);
      all_ok = all_ok && ok;
      drive_beat(4'(8 + k), rnd128(), 1'b1, 1'b0, 1'b1);
    end
    tests++; if (!all_ok) begin fails++; $display("FAIL full_issues got %0d want %0d", issued_cnt, base + 5); end
    wait_drain(ok);
    tests++; if (!ok) begin fails++; $display("FAIL full_drain got %0d pending want 0", exp_r.size()); end
  endtask

  task automatic test_credits();
    bit ok, ok2, held;
    int hs_base;
    int base = issued_cnt;
    rready = 1'b0;
    send_ar(4'h3, 32'h2000, 4'd15, ok);
    send_ar(4'h4, 32'h3000, 4'd15, ok2);
    wait_issues(base + 1, ok);
    tests++; if (!(ok && ok2)) begin fails++; $display("FAIL cred_first_issue got %0d want %0d", issued_cnt, base + 1); end
    for (int k = 0; k < 16; k++) drive_beat(4'h3, rnd128(), k == 15, 1'b0, 1'b1);
    tests++; if (dut.credits !== 5'd0) begin fails++; $display("FAIL cred_spent got %0d want 0", dut.credits); end
    held = 1'b1;
    repeat (20) begin @(negedge clk); if (req_valid) held = 1'b0; end
    tests++; if (!held) begin fails++; $display("FAIL cred_block got req_valid=1 want 0 without credits"); end
    @(posedge clk); #1;
    hs_base = r_hs_cnt;
    rready = 1'b1;
    wait_issues(base + 2, ok);
    tests++;
    if (!ok || (r_hs_cnt - hs_base) < 16) begin
      fails++; $display("FAIL cred_second_issue got issued=%0b after %0d R beats want >=16", ok, r_hs_cnt - hs_base);
    end
    for (int k = 0; k < 16; k++) drive_beat(4'h4, rnd128(), k == 15, 1'b0, 1'b1);
    wait_drain(ok);
    tests++; if (!ok) begin fails++; $display("FAIL cred_drain got %0d pending want 0", exp_r.size()); end
  endtask

  task automatic test_rready_toggle();
    bit ok;
    int stalls0;
    int base = issued_cnt;
    rready = 1'b1;
    send_ar(4'h7, 32'h4000, 4'd7, ok);
    wait_issues(base + 1, ok);
    tests++; if (!ok) begin fails++; $display("FAIL tog_issue got %0d want %0d", issued_cnt, base + 1); end
    stalls0 = stall_chk;
    fork
      for (int k = 0; k < 8; k++) drive_beat(4'h7, rnd128(), k == 7, 1'b0, 1'b1);
      begin
        repeat (24) begin rready = ~rready; @(posedge clk); #1; end
        rready = 1'b1;
      end
    join
    wait_drain(ok);
    tests++; if (!ok) begin fails++; $display("FAIL tog_drain got %0d pending want 0", exp_r.size()); end
    tests++; if (stall_chk <= stalls0) begin fails++; $display("FAIL tog_stalls got %0d stalled cycles want >0", stall_chk - stalls0); end
  endtask

  task automatic test_reset_mid_burst();
    bit ok, quiet;
    int base = issued_cnt;
    rready = 1'b1;
    send_ar(4'h5, 32'h5000, 4'd3, ok);
    wait_issues(base + 1, ok);
    tests++; if (!ok) begin fails++; $display("FAIL rst_issue got %0d want %0d", issued_cnt, base + 1); end
    drive_beat(4'h5, rnd128(), 1'b0, 1'b0, 1'b1);
    drive_beat(4'h5, rnd128(), 1'b0, 1'b0, 1'b1);
    wait_drain(ok);
    tests++; if (!ok) begin fails++; $display("FAIL rst_first_two got %0d pending want 0", exp_r.size()); end
    rready = 1'b0;
    drive_beat(4'h5, rnd128(), 1'b0, 1'b0, 1'b0);
    tests++; if (rvalid !== 1'b1) begin fails++; $display("FAIL rst_buffered got rvalid=%0b want 1", rvalid); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (rvalid !== 1'b0 || req_valid !== 1'b0 || arready !== 1'b0 || dut.credits !== 5'd16) begin
      fails++;
      $display("FAIL rst_mid_state got rvalid=%0b req_valid=%0b arready=%0b credits=%0d want 0 0 0 16",
               rvalid, req_valid, arready, dut.credits);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    rready = 1'b1;
    @(negedge clk);
    tests++; if (arready !== 1'b1 || rvalid !== 1'b0) begin fails++; $display("FAIL rst_release got arready=%0b rvalid=%0b want 1 0", arready, rvalid); end
    quiet = 1'b1;
    repeat (10) begin @(negedge clk); if (rvalid) quiet = 1'b0; end
    tests++; if (!quiet) begin fails++; $display("FAIL rst_no_stale got rvalid=1 want 0 after reset"); end
    @(posedge clk); #1;
    base = issued_cnt;
    send_ar(4'h6, 32'h6000, 4'd1, ok);
    wait_issues(base + 1, ok);
    tests++; if (!ok) begin fails++; $display("FAIL rst_new_issue got %0d want %0d", issued_cnt, base + 1); end
    drive_beat(4'h6, rnd128(), 1'b0, 1'b0, 1'b1);
    drive_beat(4'h6, rnd128(), 1'b1, 1'b0, 1'b1);
    wait_drain(ok);
    tests++; if (!ok) begin fails++; $display("FAIL rst_new_drain got %0d pending want 0", exp_r.size()); end
  endtask

`ifdef SAL_RD_PARITY_EN
  task automatic test_parity();
    bit ok;
    int base = issued_cnt;
    rready = 1'b1;
    send_ar(4'h9, 32'h7000, 4'd3, ok);
    wait_issues(base + 1, ok);
    tests++; if (!ok) begin fails++; $display("FAIL par_issue got %0d want %0d", issued_cnt, base + 1); end
    for (int k = 0; k < 4; k++) drive_beat(4'h9, rnd128(), k == 3, k == 1, 1'b1);
    wait_drain(ok);
    tests++; if (!ok) begin fails++; $display("FAIL par_drain got %0d pending want 0", exp_r.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_two_bursts();
    test_ar_full();
    test_credits();
    test_rready_toggle();
    test_reset_mid_burst();
`ifdef SAL_RD_PARITY_EN
    test_parity();
`endif
    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
